// File: rtl/la_pkg.sv
// Shared definitions for the UART transmit link: serializer state encoding
// and the default FIFO size and baud divider.
package la_pkg;

  localparam int N_FIFO_DEF   = 9;
  localparam int BAUD_DIV_DEF = 434;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/la_tx_link_if.sv
// Producer-side byte interface of the transmit link.
//   wr_i       write strobe, one byte per asserted cycle
//   data_i     byte to queue
//   full_o     FIFO full, writes are dropped while high
//   empty_o    FIFO holds no bytes
//   level_o    bytes currently stored (0..2^N_FIFO)
//   overflow_o sticky flag, a write was dropped
// master: producer side; slave: the link.
interface la_tx_link_if #(
  parameter int N_FIFO = la_pkg::N_FIFO_DEF
);

  logic              wr_i;
  logic [7:0]        data_i;
  logic              full_o;
  logic              empty_o;
  logic [N_FIFO:0]   level_o;
  logic              overflow_o;

  modport master (
    output wr_i, data_i,
    input  full_o, empty_o, level_o, overflow_o
  );

  modport slave (
    input  wr_i, data_i,
    output full_o, empty_o, level_o, overflow_o
  );

endinterface

// File: rtl/la_sync_fifo.sv
// Synchronous byte FIFO, depth 2^N_FIFO, registered (block-RAM style) read.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   wr_i, data_i  write strobe and byte; ignored while full_o
//   rd_i          pop strobe; ignored while empty_o
//   rd_data_o     popped byte, valid the cycle after rd_i
//   full_o, empty_o, level_o  status decoded from the registered level
//   overflow_o    sticky, set the cycle after a write is dropped
module la_sync_fifo #(
  parameter int N_FIFO = 9
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_i,
  input  logic [7:0]      data_i,
  input  logic            rd_i,
  output logic [7:0]      rd_data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [N_FIFO:0] level_o,
  output logic            overflow_o
);

  localparam int unsigned DEPTH = 1 << N_FIFO;

  logic [7:0]        mem [DEPTH];
  logic [N_FIFO-1:0] wr_ptr;
  logic [N_FIFO-1:0] rd_ptr;
  logic [N_FIFO:0]   level;
  logic              accept;
  logic              pop;

  // Level never exceeds DEPTH, so its MSB alone marks full.
  assign full_o  = level[N_FIFO];
  assign empty_o = (level == '0);
  assign level_o = level;

  assign accept = wr_i & ~full_o;
  assign pop    = rd_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pop) begin
      rd_data_o <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_i && full_o) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/la_tx_link.sv
// Byte FIFO feeding an 8N1 UART serializer.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   bus           producer interface (write side and FIFO status)
//   txd_o         serial line, idle high, registered
//   busy_o        serializer not idle, registered
module la_tx_link
  import la_pkg::*;
#(
  parameter int N_FIFO   = N_FIFO_DEF,
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  la_tx_link_if.slave bus,
  output logic        txd_o,
  output logic        busy_o
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  tx_state_t   state, state_nx;
  logic [15:0] baud_cnt, baud_cnt_nx;
  logic [2:0]  bit_idx, bit_idx_nx;
  logic [7:0]  shreg, shreg_nx;
  logic        pop;
  logic        line;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;

  la_sync_fifo #(
    .N_FIFO(N_FIFO)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_i      (bus.wr_i),
    .data_i    (bus.data_i),
    .rd_i      (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (bus.full_o),
    .empty_o   (fifo_empty),
    .level_o   (bus.level_o),
    .overflow_o(bus.overflow_o)
  );

  assign bus.empty_o = fifo_empty;

  always_comb begin
    state_nx    = state;
    baud_cnt_nx = baud_cnt;
    bit_idx_nx  = bit_idx;
    shreg_nx    = shreg;
    pop         = 1'b0;
    line        = 1'b1;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        shreg_nx    = fifo_rd_data;
        baud_cnt_nx = BAUD_LAST;
        state_nx    = START;
      end
      START: begin
        line = 1'b0;
        if (baud_cnt == '0) begin
          baud_cnt_nx = BAUD_LAST;
          bit_idx_nx  = '0;
          state_nx    = DATA;
        end else begin
          baud_cnt_nx = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        line = shreg[0];
        if (baud_cnt == '0) begin
          baud_cnt_nx = BAUD_LAST;
          shreg_nx    = shreg >> 1;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
          end else begin
            bit_idx_nx = bit_idx + 1'b1;
          end
        end else begin
          baud_cnt_nx = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          state_nx = IDLE;
        end else begin
          baud_cnt_nx = baud_cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // txd_o registers the level of the current state, so the line trails the
  // state by one cycle; busy_o registers the next state and tracks it exactly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd_o    <= 1'b1;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      bit_idx  <= bit_idx_nx;
      shreg    <= shreg_nx;
      txd_o    <= line;
      busy_o   <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_la_tx_link.sv
module tb_la_tx_link;

  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr  = 1'b0;
  logic [7:0] din = '0;
  logic       txd3, busy3, txd2, busy2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  la_tx_link_if #(.N_FIFO(3)) bus3 ();
  la_tx_link_if #(.N_FIFO(2)) bus2 ();

  assign bus3.wr_i   = wr;
  assign bus3.data_i = din;
  assign bus2.wr_i   = wr;
  assign bus2.data_i = din;

  la_tx_link #(.N_FIFO(3), .BAUD_DIV(B)) dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus3),
    .txd_o (txd3),
    .busy_o(busy3)
  );

  la_tx_link #(.N_FIFO(2), .BAUD_DIV(B)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2),
    .txd_o (txd2),
    .busy_o(busy2)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue per instance plus the time elapsed since
  // the serializer took its current byte. Frame time 0 is the load cycle,
  // 1..B start bit, then 8 data bits of B cycles each, then B stop cycles.
  int         depth [2] = '{8, 4};
  logic [7:0] mbuf  [2][64];
  int         mhead [2];
  int         mcnt  [2];
  int         ft    [2] = '{-1, -1};
  logic [7:0] cur   [2];
  logic       movf  [2];
  logic       mtxd  [2] = '{1'b1, 1'b1};
  bit         acc;

  function automatic logic line_level(int k, logic [7:0] b);
    if (k >= 1 && k <= B) return 1'b0;
    if (k > B && k <= 9 * B) return b[(k - B - 1) / B];
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        mhead[m] = 0;
        mcnt[m]  = 0;
        ft[m]    = -1;
        movf[m]  = 1'b0;
        mtxd[m]  = 1'b1;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        mtxd[m] = line_level(ft[m], cur[m]);
        acc = wr && (mcnt[m] < depth[m]);
        if (wr && !acc) movf[m] = 1'b1;
        if (ft[m] < 0 && mcnt[m] > 0) begin
          cur[m]   = mbuf[m][mhead[m]];
          mhead[m] = (mhead[m] + 1) % 64;
          mcnt[m]  = mcnt[m] - 1;
          ft[m]    = 0;
        end else if (ft[m] >= 0) begin
          ft[m] = ft[m] + 1;
          if (ft[m] > 10 * B) ft[m] = -1;
        end
        if (acc) begin
          mbuf[m][(mhead[m] + mcnt[m]) % 64] = din;
          mcnt[m] = mcnt[m] + 1;
        end
      end
    end
  end

  task automatic cmp_inst(string tag, int m, logic [31:0] lvl, logic emp,
                          logic ful, logic ovf, logic txd, logic bsy);
    chk({tag, " level"},    lvl, mcnt[m]);
    chk({tag, " empty"},    emp, mcnt[m] == 0);
    chk({tag, " full"},     ful, mcnt[m] == depth[m]);
    chk({tag, " overflow"}, ovf, movf[m]);
    chk({tag, " txd"},      txd, mtxd[m]);
    chk({tag, " busy"},     bsy, ft[m] >= 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp_inst("m3", 0, 32'(bus3.level_o), bus3.empty_o, bus3.full_o,
               bus3.overflow_o, txd3, busy3);
      cmp_inst("m2", 1, 32'(bus2.level_o), bus2.empty_o, bus2.full_o,
               bus2.overflow_o, txd2, busy2);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic a5_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] rxb;
  logic exp_line;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst level3", 32'(bus3.level_o), 0);
    chk("rst empty3", bus3.empty_o, 1);
    chk("rst full3",  bus3.full_o, 0);
    chk("rst ovf3",   bus3.overflow_o, 0);
    chk("rst txd3",   txd3, 1);
    chk("rst busy3",  busy3, 0);
    chk("rst txd2",   txd2, 1);
    rst = 1'b0;

    // single 0xA5 frame, k = edges after the write edge
    do_reset();
    wr = 1'b1; din = 8'hA5;
    @(negedge clk); wr = 1'b0;
    for (int k = 1; k <= 43; k++) begin
      @(negedge clk);
      if (k <= 2)       exp_line = 1'b1;
      else if (k <= 6)  exp_line = 1'b0;
      else if (k <= 38) exp_line = a5_bits[(k - 7) / 4];
      else              exp_line = 1'b1;
      chk("a5 txd", txd3, exp_line);
      if (k == 1 || k == 41) chk("a5 busy hi", busy3, 1);
      if (k == 42)           chk("a5 busy lo", busy3, 0);
    end

    // three back-to-back frames 0x00, 0xFF, 0x55
    do_reset();
    wr = 1'b1; din = 8'h00;
    @(negedge clk); din = 8'hFF;
    @(negedge clk); din = 8'h55;
    @(negedge clk); wr = 1'b0;
    for (int k = 3; k <= 130; k++) begin
      @(negedge clk);
      if (k == 7)  chk("b2b f1 bit0", txd3, 0);
      if (k == 44) chk("b2b gap", txd3, 1);
      if (k == 45) chk("b2b f2 start", txd3, 0);
      if (k == 49) chk("b2b f2 bit0", txd3, 1);
      if (k == 84) chk("b2b level before pop3", 32'(bus3.level_o), 1);
      if (k == 85) chk("b2b empty after pop3", bus3.empty_o, 1);
      if (k == 91) chk("b2b f3 bit0", txd3, 1);
      if (k == 95) chk("b2b f3 bit1", txd3, 0);
    end

    // fill to full, then write on the cycle the idle serializer pops
    do_reset();
    wr = 1'b1; din = 8'h10;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); din = 8'h10 + 8'(i);
    end
    @(negedge clk); wr = 1'b0;
    chk("fill level3", 32'(bus3.level_o), 8);
    chk("fill full3",  bus3.full_o, 1);
    chk("fill ovf3",   bus3.overflow_o, 0);
    chk("fill level2", 32'(bus2.level_o), 4);
    chk("fill ovf2",   bus2.overflow_o, 1);
    repeat (34) @(negedge clk);
    chk("full hold level3", 32'(bus3.level_o), 8);
    wr = 1'b1; din = 8'hEE;
    @(negedge clk); wr = 1'b0;
    chk("pop drop level3", 32'(bus3.level_o), 7);
    chk("pop drop full3",  bus3.full_o, 0);
    chk("pop drop ovf3",   bus3.overflow_o, 1);
    repeat (20) @(negedge clk);
    chk("ovf sticky3", bus3.overflow_o, 1);

    // asynchronous reset during data bit 3 of 0x35 (bit 3 = 0)
    do_reset();
    wr = 1'b1; din = 8'h35;
    @(negedge clk); din = 8'hC3;
    @(negedge clk); wr = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre-abort txd3",   txd3, 0);
    chk("pre-abort busy3",  busy3, 1);
    chk("pre-abort level3", 32'(bus3.level_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort txd3",   txd3, 1);
    chk("abort busy3",  busy3, 0);
    chk("abort level3", 32'(bus3.level_o), 0);
    chk("abort empty3", bus3.empty_o, 1);
    chk("abort txd2",   txd2, 1);
    chk("abort level2", 32'(bus2.level_o), 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post-abort txd3", txd3, 1);

    // pointer wrap: 20 paced bytes, decoded from the N_FIFO=2 line
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr = 1'b1; din = 8'(i);
      @(negedge clk); wr = 1'b0;
      rxb = '0;
      for (int k = 1; k <= 43; k++) begin
        @(negedge clk);
        if (k >= 8 && k <= 36 && ((k - 8) % 4) == 0) rxb[(k - 8) / 4] = txd2;
      end
      chk("wrap byte", rxb, 32'(i));
    end
    repeat (5) @(negedge clk);
    chk("wrap ovf2",   bus2.overflow_o, 0);
    chk("wrap empty2", bus2.empty_o, 1);
    chk("wrap ovf3",   bus3.overflow_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
